// File: rtl/serial_neuron_mac_pkg.sv
// serial_neuron_mac_pkg: FP32 constants and FSM state encodings shared by the neuron MAC.
`ifndef SERIAL_NEURON_MAC_PKG_SV
`define SERIAL_NEURON_MAC_PKG_SV
package serial_neuron_mac_pkg;
    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam logic [31:0] FP_CLAMP_POS = 32'h4080_0000;
    localparam logic [31:0] FP_CLAMP_NEG = 32'hC080_0000;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage
`endif

// File: rtl/FloatingAddition.sv
// FloatingAddition: combinational FP32 add, round-to-nearest, subnormals flushed to zero.
module FloatingAddition (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic              swap, rnd, carry;
    logic [31:0]       big, sml;
    logic [7:0]        d;
    logic [24:0]       mb, ms;
    logic [25:0]       raw, norm;
    logic [4:0]        sh;
    logic [22:0]       frac;
    logic signed [9:0] e;
    always_comb begin
        swap = a[30:0] < b[30:0];
        big = swap ? b : a;
        sml = swap ? a : b;
        d = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 1'b0};
        ms = {1'b1, sml[22:0], 1'b0} >> d;
        raw = big[31] == sml[31] ? {1'b0, mb} + {1'b0, ms} : {1'b0, mb} - {1'b0, ms};
        sh = 5'd0;
        for (int i = 0; i < 26; i++)
            if (raw[i]) sh = 5'(25 - i);
        norm = raw << sh;
        rnd = norm[1] & (norm[0] | norm[2]);
        {carry, frac} = {1'b0, norm[24:2]} + 24'(rnd);
        e = $signed({2'b0, big[30:23]}) + 10'sd1 - $signed({5'b0, sh}) + $signed({9'b0, carry});
        // Exact cancellation leaves no leading one and yields +0.
        sum = a[30:23] == 8'd0 ? b :
              b[30:23] == 8'd0 ? a :
              (!norm[25] || e < 10'sd1) ? 32'h0 :
              e > 10'sd254 ? {big[31], 8'hFF, 23'h0} : {big[31], e[7:0], frac};
    end
endmodule

// File: rtl/FloatingMultiplication.sv
// FloatingMultiplication: combinational FP32 multiply, round-to-nearest, subnormals flushed to zero.
module FloatingMultiplication (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);
    logic [47:0]       p;
    logic [22:0]       frac;
    logic              sign, rnd, carry;
    logic signed [9:0] e;
    always_comb begin
        sign = a[31] ^ b[31];
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        rnd = p[47] ? p[23] & (|p[22:0] | p[24]) : p[22] & (|p[21:0] | p[23]);
        {carry, frac} = {1'b0, p[47] ? p[46:24] : p[45:23]} + 24'(rnd);
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127
            + $signed({9'b0, p[47]}) + $signed({9'b0, carry});
        product = (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e < 10'sd1) ? 32'h0 :
                  e > 10'sd254 ? {sign, 8'hFF, 23'h0} : {sign, e[7:0], frac};
    end
endmodule

// File: rtl/serial_neuron_mac_fp_mac_datapath.sv
// fp_mac_datapath: acc + (bypass_mult ? b : a*b) using one FP multiplier and one FP adder.
module fp_mac_datapath (
    input  logic [31:0] acc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bypass_mult,
    output logic [31:0] sum
);
    logic [31:0] prod;
    FloatingMultiplication u_mul (.a(a), .b(b), .product(prod));
    FloatingAddition u_add (.a(acc), .b(bypass_mult ? b : prod), .sum(sum));
endmodule

// File: rtl/serial_neuron_mac.sv
// serial_neuron_mac: serial FP32 dot product plus bias feeding the softplus stage.
// Define SERIAL_NEURON_CLAMP_EN to clamp the biased sum to [-4.0, +4.0].
module serial_neuron_mac
    import serial_neuron_mac_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] w_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      acc, bias_q, mac, biased;
    logic             bypass;

    assign bypass = state == BIAS;

    // BIAS reuses the adder with the multiplier bypassed.
    fp_mac_datapath u_dp (
        .acc(acc), .a(x_in), .b(bypass ? bias_q : w_in), .bypass_mult(bypass), .sum(mac)
    );

`ifdef SERIAL_NEURON_CLAMP_EN
    assign biased = mac[30:0] > FP_CLAMP_POS[30:0] ? {mac[31], FP_CLAMP_POS[30:0]} : mac;
`else
    assign biased = mac;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= FP_ZERO;
            count     <= '0;
            bias_q    <= FP_ZERO;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= FP_ZERO;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bias_q   <= bias;
                    acc      <= FP_ZERO;
                    count    <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    state    <= ACCUM;
                end
                ACCUM: if (in_valid && in_ready) begin
                    acc   <= mac;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(N_INPUTS - 1)) begin
                        in_ready <= 1'b0;
                        state    <= BIAS;
                    end
                end
                BIAS: begin
                    acc       <= biased;
                    result    <= biased;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_neuron_mac.sv
// tb_serial_neuron_mac: directed checks of the serial neuron MAC with N_INPUTS=4 and N_INPUTS=1.
module tb_serial_neuron_mac;
    localparam logic [31:0] F_0     = 32'h0000_0000;
    localparam logic [31:0] F_1     = 32'h3F80_0000;
    localparam logic [31:0] F_2     = 32'h4000_0000;
    localparam logic [31:0] F_3     = 32'h4040_0000;
    localparam logic [31:0] F_4     = 32'h4080_0000;
    localparam logic [31:0] F_HALF  = 32'h3F00_0000;
    localparam logic [31:0] F_QTR   = 32'h3E80_0000;
    localparam logic [31:0] F_M2    = 32'hC000_0000;
    localparam logic [31:0] F_M4    = 32'hC080_0000;
    localparam logic [31:0] F_MHALF = 32'hBF00_0000;
    localparam logic [31:0] F_100   = 32'h42C8_0000;
`ifdef SERIAL_NEURON_CLAMP_EN
    localparam logic [31:0] EXP_SUM = 32'h4080_0000;
    localparam logic [31:0] EXP_ONE = 32'hC080_0000;
`else
    localparam logic [31:0] EXP_SUM = 32'h4128_0000;
    localparam logic [31:0] EXP_ONE = 32'hC0A0_0000;
`endif
    localparam logic [31:0] EXP_GAP = 32'h3F00_0000;

    logic        clk, rst_n;
    logic        start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] bias, x_in, w_in, result;
    logic        s_start, s_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [31:0] s_bias, s_x, s_w, s_result;
    int checks = 0;
    int errors = 0;

    serial_neuron_mac #(.N_INPUTS(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    serial_neuron_mac #(.N_INPUTS(1), .CNT_W(8)) dut_single (
        .clk(clk), .rst_n(rst_n), .start(s_start), .bias(s_bias),
        .in_valid(s_valid), .in_ready(s_in_ready), .x_in(s_x), .w_in(s_w),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        bias = b;
        @(negedge clk);
        start = 1'b0;
        bias = 32'hDEAD_BEEF;
    endtask

    task automatic beat(input logic [31:0] x, input logic [31:0] w);
        int t = 0;
        x_in = x;
        w_in = w;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_timeout in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b required 000", {in_ready, out_valid, busy});
        end
        checks++;
        if (result !== F_0) begin
            errors++;
            $display("FAIL reset_result got %h required %h", result, F_0);
        end
        checks++;
        if ({s_in_ready, s_out_valid, s_busy, s_result} !== 35'd0) begin
            errors++;
            $display("FAIL reset_single got %b/%h required 000/0", {s_in_ready, s_out_valid, s_busy}, s_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        do_start(F_HALF);
        beat(F_1, F_1);
        beat(F_2, F_1);
        beat(F_3, F_1);
        beat(F_4, F_1);
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL cont_bias_cycle got %b required 001", {out_valid, in_ready, busy});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL cont_latency out_valid=%b required 1", out_valid);
        end
        checks++;
        if (result !== EXP_SUM) begin
            errors++;
            $display("FAIL cont_result got %h required %h", result, EXP_SUM);
        end
        handshake();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cont_release got %b required 00", {out_valid, busy});
        end
    endtask

    task automatic test_gaps();
        do_start(F_MHALF);
        beat(F_1, F_2);
        beat(F_M2, F_1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, busy, out_valid} !== 3'b110) begin
                errors++;
                $display("FAIL gap_hold%0d got %b required 110", i, {in_ready, busy, out_valid});
            end
        end
        beat(F_HALF, F_4);
        beat(F_QTR, F_M4);
        wait_out();
        checks++;
        if (result !== EXP_GAP) begin
            errors++;
            $display("FAIL gap_result got %h required %h", result, EXP_GAP);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        do_start(F_HALF);
        beat(F_1, F_1);
        beat(F_2, F_1);
        beat(F_3, F_1);
        beat(F_4, F_1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== EXP_SUM) begin
                errors++;
                $display("FAIL bp_hold%0d got %b/%h required 1/%h", i, out_valid, result, EXP_SUM);
            end
            @(negedge clk);
        end
        handshake();
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL bp_idle got %b required 000", {out_valid, busy, in_ready});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_stay_idle got %b required 00", {out_valid, busy});
        end
    endtask

    task automatic test_start_ignored();
        do_start(F_HALF);
        beat(F_1, F_1);
        beat(F_2, F_1);
        start = 1'b1;
        bias = F_100;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL start_accum got %b required 11", {busy, in_ready});
        end
        beat(F_3, F_1);
        beat(F_4, F_1);
        wait_out();
        start = 1'b1;
        bias = F_100;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== EXP_SUM) begin
            errors++;
            $display("FAIL start_done got %b/%h required 1/%h", out_valid, result, EXP_SUM);
        end
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL start_handshake got %b required 00", {busy, out_valid});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== EXP_SUM) begin
            errors++;
            $display("FAIL start_after got %b/%h required 0/%h", busy, result, EXP_SUM);
        end
    endtask

    task automatic test_reset_mid();
        do_start(F_HALF);
        beat(F_4, F_4);
        beat(F_4, F_4);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || result !== F_0) begin
            errors++;
            $display("FAIL async_reset got %b/%h required 000/%h", {in_ready, out_valid, busy}, result, F_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(F_0);
        for (int i = 0; i < 4; i++) beat(F_1, F_1);
        wait_out();
        checks++;
        if (result !== F_4) begin
            errors++;
            $display("FAIL reset_rerun got %h required %h", result, F_4);
        end
        handshake();
    endtask

    task automatic test_single_input();
        s_start = 1'b1;
        s_bias = F_1;
        @(negedge clk);
        s_start = 1'b0;
        s_x = F_3;
        s_w = F_M2;
        s_valid = 1'b1;
        checks++;
        if (s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b required 1", s_in_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if ({s_out_valid, s_in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL single_bias_cycle got %b required 00", {s_out_valid, s_in_ready});
        end
        @(negedge clk);
        checks++;
        if (s_out_valid !== 1'b1 || s_result !== EXP_ONE) begin
            errors++;
            $display("FAIL single_result got %b/%h required 1/%h", s_out_valid, s_result, EXP_ONE);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        checks++;
        if ({s_busy, s_out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_release got %b required 00", {s_busy, s_out_valid});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {start, in_valid, out_ready} = 3'b000;
        bias = F_0;
        x_in = F_0;
        w_in = F_0;
        {s_start, s_valid, s_out_ready} = 3'b000;
        s_bias = F_0;
        s_x = F_0;
        s_w = F_0;
        test_reset();
        test_continuous();
        test_gaps();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_single_input();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
